// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the guessing-game sequencer.
package game_pkg;

  localparam int SHAPE_W   = 3;
  localparam int NUM_SLOTS = 4;
  localparam int PATTERN_W = SHAPE_W * NUM_SLOTS;

  // Codes 000 and 111 are reserved and never stored in the pattern.
  typedef enum logic [SHAPE_W-1:0] {
    SHAPE_NONE     = 3'b000,
    SHAPE_CIRCLE   = 3'b001,
    SHAPE_SQUARE   = 3'b010,
    SHAPE_TRIANGLE = 3'b011,
    SHAPE_DIAMOND  = 3'b100,
    SHAPE_STAR     = 3'b101,
    SHAPE_HEART    = 3'b110,
    SHAPE_RSVD     = 3'b111
  } shape_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    GRADING,
    DONE
  } seq_state_t;

  function automatic logic isValidShape(input logic [SHAPE_W-1:0] code);
    return (code != SHAPE_NONE) && (code != SHAPE_RSVD);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Grading handshake between the sequencer (master) and the guess grader (slave).
interface game_sequencer_if;
  import game_pkg::*;

  logic                 grade_start;
  logic                 grade_done;
  logic                 grade_won;
  logic [PATTERN_W-1:0] masterPattern;

  modport master (
    output grade_start,
    output masterPattern,
    input  grade_done,
    input  grade_won
  );

  modport slave (
    input  grade_start,
    input  masterPattern,
    output grade_done,
    output grade_won
  );

endinterface

// File: rtl/game_sequencer_rise_detect.sv
// Registered-history rising-edge detector; pulse is high in the cycle the input first reads 1.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic levelPrev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      levelPrev <= 1'b0;
    end else begin
      levelPrev <= level;
    end
  end

  assign pulse = level & ~levelPrev;

endmodule

// File: rtl/game_sequencer.sv
// Guessing-game controller: credits, master-pattern loading, rounds and grading handshake.
// Define GAME_SEQUENCER_DEBUG_EN to expose masterPattern on masterView in every state.
module game_sequencer
  import game_pkg::*;
#(
  parameter int MAX_ROUNDS = 8,
  parameter int MAX_GAMES  = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 credit_add,
  input  logic                 StartGame,
  input  logic [SHAPE_W-1:0]   LoadShape,
  input  logic [1:0]           ShapeLocation,
  input  logic                 LoadShapeNow,
  input  logic                 GradeIt,
  game_sequencer_if.master     grader,
  output logic [PATTERN_W-1:0] masterView,
  output logic [3:0]           NumGames,
  output logic [3:0]           RoundNumber,
  output logic                 GameWon,
  output logic                 ongoingGame,
  output logic                 loadingShape
);

  localparam logic [3:0] MaxRoundsL = 4'(MAX_ROUNDS);
  localparam logic [3:0] MaxGamesL  = 4'(MAX_GAMES);

  seq_state_t           state;
  seq_state_t           nextState;
  logic                 startEdge;
  logic                 loadEdge;
  logic                 gradeEdge;
  logic [NUM_SLOTS-1:0] slotMask;
  logic [PATTERN_W-1:0] patternReg;
  logic                 gradeStartReg;
  logic                 beginGame;
  logic                 writeSlot;
  logic                 issueGrade;
  logic                 setWon;

  rise_detect startDetect (.clock(clock), .reset(reset), .level(StartGame),    .pulse(startEdge));
  rise_detect loadDetect  (.clock(clock), .reset(reset), .level(LoadShapeNow), .pulse(loadEdge));
  rise_detect gradeDetect (.clock(clock), .reset(reset), .level(GradeIt),      .pulse(gradeEdge));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // DONE accepts a new game exactly like IDLE; GRADING ignores all player inputs.
  always_comb begin
    nextState  = state;
    beginGame  = 1'b0;
    writeSlot  = 1'b0;
    issueGrade = 1'b0;
    setWon     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (startEdge && (NumGames != 4'd0)) begin
          nextState = LOAD;
          beginGame = 1'b1;
        end
      end
      LOAD: begin
        if (slotMask == '1) begin
          nextState = PLAY;
        end
        if (loadEdge && isValidShape(LoadShape)) begin
          writeSlot = 1'b1;
        end
      end
      PLAY: begin
        if (gradeEdge) begin
          nextState  = GRADING;
          issueGrade = 1'b1;
        end
      end
      GRADING: begin
        if (grader.grade_done) begin
          if (grader.grade_won) begin
            nextState = DONE;
            setWon    = 1'b1;
          end else if (RoundNumber == MaxRoundsL) begin
            nextState = DONE;
          end else begin
            nextState = PLAY;
          end
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // A purchase and a game start in the same cycle cancel out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      NumGames <= 4'd0;
    end else if (beginGame && !credit_add) begin
      NumGames <= NumGames - 4'd1;
    end else if (credit_add && !beginGame && (NumGames < MaxGamesL)) begin
      NumGames <= NumGames + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      patternReg    <= '0;
      slotMask      <= '0;
      RoundNumber   <= 4'd0;
      GameWon       <= 1'b0;
      gradeStartReg <= 1'b0;
    end else begin
      gradeStartReg <= issueGrade;
      if (beginGame) begin
        patternReg  <= '0;
        slotMask    <= '0;
        RoundNumber <= 4'd0;
        GameWon     <= 1'b0;
      end
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (writeSlot && (ShapeLocation == 2'(k))) begin
          patternReg[k*SHAPE_W +: SHAPE_W] <= LoadShape;
          slotMask[k]                      <= 1'b1;
        end
      end
      if (issueGrade) begin
        RoundNumber <= RoundNumber + 4'd1;
      end
      if (setWon) begin
        GameWon <= 1'b1;
      end
    end
  end

  assign grader.grade_start   = gradeStartReg;
  assign grader.masterPattern = patternReg;
  assign ongoingGame          = (state == PLAY) || (state == GRADING);
  assign loadingShape         = (state == LOAD);

`ifdef GAME_SEQUENCER_DEBUG_EN
  assign masterView = patternReg;
`else
  assign masterView = (state == DONE) ? patternReg : '0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Directed-vector bench for game_sequencer: a stimulus/expectation table plus multi-cycle sequences.
module tb_game_sequencer;
  import game_pkg::*;

  typedef struct packed {
    logic       credit;
    logic       start;
    logic       loadNow;
    logic [2:0] shape;
    logic [1:0] loc;
    logic       grade;
    logic       done;
    logic       won;
  } ins_t;

  typedef struct packed {
    logic [3:0]  numGames;
    logic [3:0]  round;
    logic        won;
    logic        ongoing;
    logic        loading;
    logic        gradeStart;
    logic [11:0] pattern;
    logic [11:0] view;
  } outs_t;

  typedef struct packed {
    ins_t  stim;
    outs_t want;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        creditAdd;
  logic        startGame;
  logic [2:0]  loadShape;
  logic [1:0]  shapeLocation;
  logic        loadShapeNow;
  logic        gradeIt;
  logic [11:0] masterView;
  logic [3:0]  numGames;
  logic [3:0]  roundNumber;
  logic        gameWon;
  logic        ongoingGame;
  logic        loadingShape;

  int checks;
  int failures;
  vec_t vecs[$];

  game_sequencer_if gif ();

  game_sequencer #(.MAX_ROUNDS(8), .MAX_GAMES(7)) dut (
    .clock(clock),
    .reset(reset),
    .credit_add(creditAdd),
    .StartGame(startGame),
    .LoadShape(loadShape),
    .ShapeLocation(shapeLocation),
    .LoadShapeNow(loadShapeNow),
    .GradeIt(gradeIt),
    .grader(gif),
    .masterView(masterView),
    .NumGames(numGames),
    .RoundNumber(roundNumber),
    .GameWon(gameWon),
    .ongoingGame(ongoingGame),
    .loadingShape(loadingShape)
  );

  always #5 clock = ~clock;

  function automatic ins_t inV(input int cr, input int st, input int ln, input int sh,
                               input int loc, input int gr, input int dn, input int wn);
    ins_t s;
    s.credit  = 1'(cr);
    s.start   = 1'(st);
    s.loadNow = 1'(ln);
    s.shape   = 3'(sh);
    s.loc     = 2'(loc);
    s.grade   = 1'(gr);
    s.done    = 1'(dn);
    s.won     = 1'(wn);
    return s;
  endfunction

  function automatic outs_t outV(input int ng, input int rd, input int gw, input int og,
                                 input int ld, input int gs, input int pat, input int view);
    outs_t o;
    o.numGames   = 4'(ng);
    o.round      = 4'(rd);
    o.won        = 1'(gw);
    o.ongoing    = 1'(og);
    o.loading    = 1'(ld);
    o.gradeStart = 1'(gs);
    o.pattern    = 12'(pat);
    o.view       = 12'(view);
    return o;
  endfunction

  task automatic addRow(input ins_t s, input outs_t e);
    vec_t v;
    v.stim = s;
    v.want = e;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input ins_t s);
    creditAdd      = s.credit;
    startGame      = s.start;
    loadShapeNow   = s.loadNow;
    loadShape      = s.shape;
    shapeLocation  = s.loc;
    gradeIt        = s.grade;
    gif.grade_done = s.done;
    gif.grade_won  = s.won;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    outs_t want;
    want = exp;
`ifdef GAME_SEQUENCER_DEBUG_EN
    want.view = exp.pattern;
`endif
    act = {numGames, roundNumber, gameWon, ongoingGame, loadingShape,
           gif.grade_start, gif.masterPattern, masterView};
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: got ng=%0d rd=%0d won=%b og=%b ld=%b gs=%b pat=%h view=%h, expected ng=%0d rd=%0d won=%b og=%b ld=%b gs=%b pat=%h view=%h",
               name, act.numGames, act.round, act.won, act.ongoing, act.loading, act.gradeStart,
               act.pattern, act.view, want.numGames, want.round, want.won, want.ongoing,
               want.loading, want.gradeStart, want.pattern, want.view);
    end
  endtask

  task automatic loadSlot(input int sh, input int loc);
    loadShape     = 3'(sh);
    shapeLocation = 2'(loc);
    loadShapeNow  = 1'b1;
    step();
    loadShapeNow  = 1'b0;
    step();
  endtask

  // Rows run back to back from reset; each applies inputs for one clock then checks.
  task automatic buildTable();
    //           cr st ln sh loc gr dn wn        ng rd gw og ld gs pat     view
    addRow(inV(0, 1, 0, 0, 0, 0, 0, 0), outV(0, 0, 0, 0, 0, 0, 'h000, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 0, 0, 0), outV(0, 0, 0, 0, 0, 0, 'h000, 'h000));
    addRow(inV(1, 0, 0, 0, 0, 0, 0, 0), outV(1, 0, 0, 0, 0, 0, 'h000, 'h000));
    addRow(inV(0, 1, 0, 0, 0, 0, 0, 0), outV(0, 0, 0, 0, 1, 0, 'h000, 'h000));
    addRow(inV(1, 0, 0, 0, 0, 0, 0, 0), outV(1, 0, 0, 0, 1, 0, 'h000, 'h000));
    for (int n = 2; n <= 9; n++) begin
      addRow(inV(1, 0, 0, 0, 0, 0, 0, 0), outV((n > 7) ? 7 : n, 0, 0, 0, 1, 0, 'h000, 'h000));
    end
    addRow(inV(0, 0, 1, 1, 0, 0, 0, 0), outV(7, 0, 0, 0, 1, 0, 'h001, 'h000));
    addRow(inV(0, 0, 1, 3, 0, 0, 0, 0), outV(7, 0, 0, 0, 1, 0, 'h001, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 0, 0, 0), outV(7, 0, 0, 0, 1, 0, 'h001, 'h000));
    addRow(inV(0, 0, 1, 6, 1, 0, 0, 0), outV(7, 0, 0, 0, 1, 0, 'h031, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 0, 0, 0), outV(7, 0, 0, 0, 1, 0, 'h031, 'h000));
    addRow(inV(0, 0, 1, 2, 1, 0, 0, 0), outV(7, 0, 0, 0, 1, 0, 'h011, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 0, 0, 0), outV(7, 0, 0, 0, 1, 0, 'h011, 'h000));
    addRow(inV(0, 0, 1, 5, 2, 0, 0, 0), outV(7, 0, 0, 0, 1, 0, 'h151, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 0, 0, 0), outV(7, 0, 0, 0, 1, 0, 'h151, 'h000));
    addRow(inV(0, 0, 1, 7, 3, 0, 0, 0), outV(7, 0, 0, 0, 1, 0, 'h151, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 0, 0, 0), outV(7, 0, 0, 0, 1, 0, 'h151, 'h000));
    addRow(inV(0, 0, 1, 0, 3, 0, 0, 0), outV(7, 0, 0, 0, 1, 0, 'h151, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 0, 0, 0), outV(7, 0, 0, 0, 1, 0, 'h151, 'h000));
    addRow(inV(0, 0, 1, 4, 3, 0, 0, 0), outV(7, 0, 0, 0, 1, 0, 'h951, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 0, 0, 0), outV(7, 0, 0, 1, 0, 0, 'h951, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 1, 0, 0), outV(7, 1, 0, 1, 0, 1, 'h951, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 1, 0, 0), outV(7, 1, 0, 1, 0, 0, 'h951, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 1, 0, 0), outV(7, 1, 0, 1, 0, 0, 'h951, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 0, 0, 0), outV(7, 1, 0, 1, 0, 0, 'h951, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 1, 0, 0), outV(7, 1, 0, 1, 0, 0, 'h951, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 0, 1, 0), outV(7, 1, 0, 1, 0, 0, 'h951, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 0, 1, 1), outV(7, 1, 0, 1, 0, 0, 'h951, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 1, 0, 0), outV(7, 2, 0, 1, 0, 1, 'h951, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 0, 0, 0), outV(7, 2, 0, 1, 0, 0, 'h951, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 0, 1, 1), outV(7, 2, 1, 0, 0, 0, 'h951, 'h951));
    addRow(inV(0, 0, 0, 0, 0, 0, 0, 0), outV(7, 2, 1, 0, 0, 0, 'h951, 'h951));
    addRow(inV(0, 0, 1, 1, 0, 0, 0, 0), outV(7, 2, 1, 0, 0, 0, 'h951, 'h951));
    addRow(inV(0, 1, 0, 0, 0, 0, 0, 0), outV(6, 0, 0, 0, 1, 0, 'h000, 'h000));
    addRow(inV(0, 0, 0, 0, 0, 0, 0, 0), outV(6, 0, 0, 0, 1, 0, 'h000, 'h000));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    applyStimulus('0);
    buildTable();

    step();
    step();
    checkOutput("reset_state", outV(0, 0, 0, 0, 0, 0, 'h000, 'h000));
    reset = 1'b0;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].stim);
      step();
      checkOutput($sformatf("vec%0d", k), vecs[k].want);
    end
    applyStimulus('0);

    // Full game lost on the last allowed round.
    loadSlot(6, 0);
    loadSlot(3, 1);
    loadSlot(1, 2);
    loadSlot(2, 3);
    checkOutput("maxr_play", outV(6, 0, 0, 1, 0, 0, 'h45E, 'h000));
    for (int r = 1; r <= 8; r++) begin
      gradeIt = 1'b1;
      step();
      checkOutput($sformatf("maxr_start%0d", r), outV(6, r, 0, 1, 0, 1, 'h45E, 'h000));
      gradeIt        = 1'b0;
      gif.grade_done = 1'b1;
      gif.grade_won  = 1'b0;
      step();
      gif.grade_done = 1'b0;
      if (r < 8) begin
        checkOutput($sformatf("maxr_back%0d", r), outV(6, r, 0, 1, 0, 0, 'h45E, 'h000));
      end else begin
        checkOutput("maxr_lost", outV(6, 8, 0, 0, 0, 0, 'h45E, 'h45E));
      end
    end

    // Reset discards credits; then purchase and start collide in one cycle.
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("reset_clear", outV(0, 0, 0, 0, 0, 0, 'h000, 'h000));
    repeat (3) begin
      creditAdd = 1'b1;
      step();
      creditAdd = 1'b0;
      step();
    end
    checkOutput("three_credits", outV(3, 0, 0, 0, 0, 0, 'h000, 'h000));
    startGame = 1'b1;
    creditAdd = 1'b1;
    step();
    creditAdd = 1'b0;
    startGame = 1'b0;
    checkOutput("credit_and_start", outV(3, 0, 0, 0, 1, 0, 'h000, 'h000));

    // Asynchronous reset while the grader is busy.
    loadSlot(6, 0);
    loadSlot(3, 1);
    loadSlot(1, 2);
    loadSlot(2, 3);
    gradeIt = 1'b1;
    step();
    checkOutput("grading_entry", outV(3, 1, 0, 1, 0, 1, 'h45E, 'h000));
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", outV(0, 0, 0, 0, 0, 0, 'h000, 'h000));
    step();
    checkOutput("reset_held", outV(0, 0, 0, 0, 0, 0, 'h000, 'h000));
    reset = 1'b0;
    step();
    checkOutput("after_reset", outV(0, 0, 0, 0, 0, 0, 'h000, 'h000));
    gradeIt = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
